lab1_regfile_sequencer: RTL and testbench

Command sequencer that owns all ports of the 4-entry, W-bit `lab1_registerfile`. It accepts one register-transfer command at a time over a valid/ready handshake, reads operands through `sel1`/`sel2`, computes a small ALU result and writes it back through `sel_dest`/`we`. It sits between a command source (a test FSM or instruction decoder) and the register file, so nothing else drives the file's control inputs.

---
 rtl/lab1_regfile_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_lab1_regfile_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab1_regfile_sequencer.sv
// -----------------------------------------------------------------------------
// lab1_regfile_sequencer
//
// Command sequencer that owns every control input of the 4-entry, W-bit
// lab1_registerfile. One register-transfer command is accepted at a time over
// a valid/ready handshake. Operands are read through rf_sel1/rf_sel2, a small
// ALU computes the result, and it is written back through rf_sel_dest/rf_we.
//
// Sequence per command: IDLE -> READ -> EXEC -> WRITE -> IDLE, or
// IDLE -> CLR -> IDLE for the clear opcode.
//
// Ports
//   clk                         system clock, rising edge
//   reset                       synchronous, active-low reset
//   cmd_valid / cmd_ready       command handshake
//   cmd_op                      opcode (READ, LOADI, ADD, SUB, AND, OR, XOR, CLR)
//   cmd_src1/cmd_src2/cmd_dst   register indices
//   cmd_imm                     immediate for LOADI
//   rf_we, rf_clr, rf_in        register file write enable, clear, write data
//   rf_sel1/rf_sel2/rf_sel_dest register file selects
//   rf_out1, rf_out2            register file read data
//   res_valid / res_data        one-cycle result pulse, last non-CLR result
//   busy                        high in every state except IDLE
// -----------------------------------------------------------------------------
module lab1_regfile_sequencer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [1:0]   cmd_src1,
  input  logic [1:0]   cmd_src2,
  input  logic [1:0]   cmd_dst,
  input  logic [W-1:0] cmd_imm,
  output logic         rf_we,
  output logic         rf_clr,
  output logic [W-1:0] rf_in,
  output logic [1:0]   rf_sel1,
  output logic [1:0]   rf_sel2,
  output logic [1:0]   rf_sel_dest,
  input  logic [W-1:0] rf_out1,
  input  logic [W-1:0] rf_out2,
  output logic         res_valid,
  output logic [W-1:0] res_data,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_CLR
  } state_t;

  typedef enum logic [2:0] {
    OP_READ  = 3'b000,
    OP_LOADI = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_AND   = 3'b100,
    OP_OR    = 3'b101,
    OP_XOR   = 3'b110,
    OP_CLR   = 3'b111
  } op_t;

  state_t       state;
  state_t       state_nxt;

  // Latched command fields
  op_t          op_q;
  logic [1:0]   src1_q;
  logic [1:0]   src2_q;
  logic [1:0]   dst_q;
  logic [W-1:0] imm_q;

  // Result and write-port registers; they hold outside WRITE
  logic [W-1:0] alu_res;
  logic [W-1:0] res_q;
  logic [W-1:0] rf_in_q;
  logic [1:0]   sel_dest_q;

  logic         accept;

  assign accept = cmd_valid & cmd_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register, independent of
  // process evaluation order.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next state and control outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case so that
  // no path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rf_we     = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    // The file is cleared together with the sequencer while reset is low.
    rf_clr    = ~reset;

    unique case (state)
      S_IDLE: begin
        busy      = 1'b0;
        cmd_ready = reset;
        if (accept) state_nxt = (op_t'(cmd_op) == OP_CLR) ? S_CLR : S_READ;
      end
      S_READ:  state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_WRITE;
      S_WRITE: begin
        // Gating with reset suppresses the write when reset lands on WRITE.
        rf_we     = reset & (op_q != OP_READ);
        res_valid = reset;
        state_nxt = S_IDLE;
      end
      S_CLR: begin
        rf_clr    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU: modulo-2^W arithmetic, carry and borrow discarded
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_res = '0;
    unique case (op_q)
      OP_READ:  alu_res = rf_out1;
      OP_LOADI: alu_res = imm_q;
      OP_ADD:   alu_res = rf_out1 + rf_out2;
      OP_SUB:   alu_res = rf_out1 - rf_out2;
      OP_AND:   alu_res = rf_out1 & rf_out2;
      OP_OR:    alu_res = rf_out1 | rf_out2;
      OP_XOR:   alu_res = rf_out1 ^ rf_out2;
      OP_CLR:   alu_res = res_q;
      default:  alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q       <= OP_READ;
      src1_q     <= '0;
      src2_q     <= '0;
      dst_q      <= '0;
      imm_q      <= '0;
      res_q      <= '0;
      rf_in_q    <= '0;
      sel_dest_q <= '0;
    end else begin
      if (accept) begin
        op_q   <= op_t'(cmd_op);
        src1_q <= cmd_src1;
        src2_q <= cmd_src2;
        dst_q  <= cmd_dst;
        imm_q  <= cmd_imm;
      end
      // Operands have had the whole READ cycle plus EXEC to settle, so both
      // combinational and one-cycle-registered read ports are sampled
      // correctly here. Sampling before WRITE makes src==dst aliasing safe.
      if (state == S_EXEC) begin
        res_q      <= alu_res;
        rf_in_q    <= alu_res;
        sel_dest_q <= dst_q;
      end
    end
  end

  // Read selects come straight from the latched sources, so they are valid
  // from READ and held through EXEC and WRITE.
  assign rf_sel1     = src1_q;
  assign rf_sel2     = src2_q;
  assign rf_sel_dest = sel_dest_q;
  assign rf_in       = rf_in_q;
  assign res_data    = res_q;

endmodule

// File: tb/tb_lab1_regfile_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lab1_regfile_sequencer
//
// Self-checking bench for lab1_regfile_sequencer. A behavioural register file
// answers the sequencer's read ports; an independent model (an int array per
// register updated from each command's arithmetic) predicts every result.
// -----------------------------------------------------------------------------
module tb_lab1_regfile_sequencer;

  localparam int W   = 3;
  localparam int MOD = 1 << W;

  localparam logic [2:0] OP_READ  = 3'd0;
  localparam logic [2:0] OP_LOADI = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_CLR   = 3'd7;

  logic         clk;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [1:0]   cmd_src1;
  logic [1:0]   cmd_src2;
  logic [1:0]   cmd_dst;
  logic [W-1:0] cmd_imm;
  logic         rf_we;
  logic         rf_clr;
  logic [W-1:0] rf_in;
  logic [1:0]   rf_sel1;
  logic [1:0]   rf_sel2;
  logic [1:0]   rf_sel_dest;
  logic [W-1:0] rf_out1;
  logic [W-1:0] rf_out2;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic         busy;

  lab1_regfile_sequencer #(.W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_src1   (cmd_src1),
    .cmd_src2   (cmd_src2),
    .cmd_dst    (cmd_dst),
    .cmd_imm    (cmd_imm),
    .rf_we      (rf_we),
    .rf_clr     (rf_clr),
    .rf_in      (rf_in),
    .rf_sel1    (rf_sel1),
    .rf_sel2    (rf_sel2),
    .rf_sel_dest(rf_sel_dest),
    .rf_out1    (rf_out1),
    .rf_out2    (rf_out2),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register file: clear has priority, combinational reads.
  logic [W-1:0] rf_mem [4];
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 4; i++) rf_mem[i] <= '0;
    end else if (rf_we) begin
      rf_mem[rf_sel_dest] <= rf_in;
    end
  end
  assign rf_out1 = rf_mem[rf_sel1];
  assign rf_out2 = rf_mem[rf_sel2];

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int ref_rf [4];
  int last_res;

  typedef struct packed {
    logic [2:0]   op;
    logic [1:0]   s1;
    logic [1:0]   s2;
    logic [1:0]   d;
    logic [W-1:0] imm;
    logic [W-1:0] exp;
  } cmd_t;

  function automatic logic [W-1:0] model_result(input cmd_t c);
    int a = ref_rf[c.s1];
    int b = ref_rf[c.s2];
    int r;
    case (c.op)
      3'd0:    r = a;
      3'd1:    r = int'(c.imm);
      3'd2:    r = a + b;
      3'd3:    r = a - b + MOD;
      3'd4:    r = a & b;
      3'd5:    r = a | b;
      3'd6:    r = a ^ b;
      default: r = last_res;
    endcase
    return W'(r % MOD);
  endfunction

  task automatic model_apply(input cmd_t c);
    int r;
    if (c.op == OP_CLR) begin
      for (int i = 0; i < 4; i++) ref_rf[i] = 0;
    end else begin
      r = int'(model_result(c));
      if (c.op != OP_READ) ref_rf[c.d] = r;
      last_res = r;
    end
  endtask

  function automatic logic [31:0] model_file();
    return {20'd0, W'(ref_rf[3]), W'(ref_rf[2]), W'(ref_rf[1]), W'(ref_rf[0])};
  endfunction

  function automatic logic [31:0] env_file();
    return {20'd0, rf_mem[3], rf_mem[2], rf_mem[1], rf_mem[0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {rf_we, res_valid, rf_clr, cmd_ready, busy}
  function automatic logic [31:0] ctl();
    return {27'd0, rf_we, res_valid, rf_clr, cmd_ready, busy};
  endfunction

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_cmd(input cmd_t c, input string tag);
    int waited = 0;
    cmd_op    = c.op;
    cmd_src1  = c.s1;
    cmd_src2  = c.s2;
    cmd_dst   = c.d;
    cmd_imm   = c.imm;
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " accept"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    // Fields must be ignored once the command is latched.
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom);
    cmd_src1  = 2'($urandom);
    cmd_src2  = 2'($urandom);
    cmd_dst   = 2'($urandom);
    cmd_imm   = W'($urandom);
    if (c.op == OP_CLR) begin
      @(negedge clk);
      check({tag, " clr cycle"}, ctl(), 32'b00101);
      @(negedge clk);
      check({tag, " clr done"}, ctl(), 32'b00010);
      check({tag, " res kept"}, 32'(res_data), 32'(last_res));
    end else begin
      @(negedge clk);
      check({tag, " read ctl"}, ctl(), 32'b00001);
      check({tag, " sels"}, {28'd0, rf_sel1, rf_sel2}, {28'd0, c.s1, c.s2});
      @(negedge clk);
      check({tag, " exec ctl"}, ctl(), 32'b00001);
      @(negedge clk);
      check({tag, " write ctl"}, ctl(), {27'd0, (c.op != OP_READ), 4'b1001});
      check({tag, " res"}, 32'(res_data), 32'(c.exp));
      if (c.op != OP_READ)
        check({tag, " wport"}, {27'd0, rf_sel_dest, rf_in}, {27'd0, c.d, c.exp});
      @(negedge clk);
      check({tag, " idle ctl"}, ctl(), 32'b00010);
    end
    model_apply(c);
    check({tag, " file"}, env_file(), model_file());
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Test
  // ---------------------------------------------------------------------------
  cmd_t tbl [6];
  cmd_t b2b [3];

  initial begin
    tbl[0] = '{op: OP_LOADI, s1: 2'd0, s2: 2'd0, d: 2'd1, imm: 3'd5, exp: 3'd5};
    tbl[1] = '{op: OP_LOADI, s1: 2'd0, s2: 2'd0, d: 2'd2, imm: 3'd3, exp: 3'd3};
    tbl[2] = '{op: OP_ADD,   s1: 2'd1, s2: 2'd2, d: 2'd3, imm: 3'd0, exp: 3'd0};
    tbl[3] = '{op: OP_READ,  s1: 2'd3, s2: 2'd0, d: 2'd1, imm: 3'd0, exp: 3'd0};
    tbl[4] = '{op: OP_SUB,   s1: 2'd2, s2: 2'd1, d: 2'd0, imm: 3'd0, exp: 3'd6};
    tbl[5] = '{op: OP_READ,  s1: 2'd0, s2: 2'd3, d: 2'd2, imm: 3'd0, exp: 3'd6};
    b2b[0] = '{op: OP_LOADI, s1: 2'd0, s2: 2'd0, d: 2'd0, imm: 3'd1, exp: 3'd1};
    b2b[1] = '{op: OP_LOADI, s1: 2'd0, s2: 2'd0, d: 2'd1, imm: 3'd5, exp: 3'd5};
    b2b[2] = '{op: OP_LOADI, s1: 2'd0, s2: 2'd0, d: 2'd3, imm: 3'd2, exp: 3'd2};

    for (int i = 0; i < 4; i++) ref_rf[i] = 0;
    last_res  = 0;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_src1  = '0;
    cmd_src2  = '0;
    cmd_dst   = '0;
    cmd_imm   = '0;

    // Reset held for two cycles
    @(negedge clk);
    check("reset clr/ready c1", {30'd0, rf_clr, cmd_ready}, 32'b10);
    @(negedge clk);
    check("reset ctl c2", ctl(), 32'b00100);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("post reset ctl", ctl(), 32'b00010);
    check("post reset res", 32'(res_data), 32'd0);
    check("post reset ports", {25'd0, rf_sel1, rf_sel2, rf_sel_dest, rf_in}, 32'd0);
    @(posedge clk);
    #1;

    // Directed table: LOADI/ADD wrap/READ, SUB borrow/READ
    for (int i = 0; i < 6; i++) run_cmd(tbl[i], $sformatf("tbl%0d", i));

    // Back-to-back with cmd_valid held high
    begin
      int acc_cyc [3];
      int cyc = 0;
      int n = 0;
      int waited = 0;
      cmd_op    = b2b[0].op;
      cmd_src1  = b2b[0].s1;
      cmd_src2  = b2b[0].s2;
      cmd_dst   = b2b[0].d;
      cmd_imm   = b2b[0].imm;
      cmd_valid = 1'b1;
      while (n < 3 && cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (cmd_ready) begin
          acc_cyc[n] = cyc;
          model_apply(b2b[n]);
          n++;
          @(posedge clk);
          #1;
          if (n < 3) begin
            cmd_op   = b2b[n].op;
            cmd_src1 = b2b[n].s1;
            cmd_src2 = b2b[n].s2;
            cmd_dst  = b2b[n].d;
            cmd_imm  = b2b[n].imm;
          end else begin
            cmd_valid = 1'b0;
          end
        end
      end
      cmd_valid = 1'b0;
      check("b2b accepts", 32'(n), 32'd3);
      if (n == 3) begin
        check("b2b gap 0-1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
        check("b2b gap 1-2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
      end
      @(negedge clk);
      while (!cmd_ready && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      check("b2b drain", 32'(cmd_ready), 32'd1);
      check("b2b file", env_file(), model_file());
      @(posedge clk);
      #1;
    end

    // Aliasing: r1 = r1 + r1 with r1 = 5
    run_cmd('{op: OP_ADD, s1: 2'd1, s2: 2'd1, d: 2'd1, imm: 3'd0, exp: 3'd2}, "alias");

    // Reset asserted during the WRITE of LOADI r2=7
    cmd_op    = OP_LOADI;
    cmd_dst   = 2'd2;
    cmd_imm   = 3'd7;
    cmd_valid = 1'b1;
    @(negedge clk);
    check("rstw accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rstw write ctl", ctl(), 32'b00101);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rstw held ctl", ctl(), 32'b00100);
    check("rstw res", 32'(res_data), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) ref_rf[i] = 0;
    last_res = 0;
    @(negedge clk);
    check("rstw release ctl", ctl(), 32'b00010);
    check("rstw file", env_file(), model_file());
    @(posedge clk);
    #1;
    run_cmd('{op: OP_READ, s1: 2'd2, s2: 2'd0, d: 2'd0, imm: 3'd0, exp: 3'd0}, "rstw read r2");

    // CLR after loading 1,2,4,7
    run_cmd('{op: OP_LOADI, s1: 2'd0, s2: 2'd0, d: 2'd0, imm: 3'd1, exp: 3'd1}, "ld r0");
    run_cmd('{op: OP_LOADI, s1: 2'd0, s2: 2'd0, d: 2'd1, imm: 3'd2, exp: 3'd2}, "ld r1");
    run_cmd('{op: OP_LOADI, s1: 2'd0, s2: 2'd0, d: 2'd2, imm: 3'd4, exp: 3'd4}, "ld r2");
    run_cmd('{op: OP_LOADI, s1: 2'd0, s2: 2'd0, d: 2'd3, imm: 3'd7, exp: 3'd7}, "ld r3");
    run_cmd('{op: OP_CLR, s1: 2'd0, s2: 2'd0, d: 2'd0, imm: 3'd0, exp: 3'd0}, "clr");
    for (int i = 0; i < 4; i++)
      run_cmd('{op: OP_READ, s1: 2'(i), s2: 2'd0, d: 2'd0, imm: 3'd0, exp: 3'd0},
              $sformatf("clr read r%0d", i));

    // Randomized commands against the model
    for (int i = 0; i < 60; i++) begin
      cmd_t c;
      c.op  = 3'($urandom_range(0, 7));
      if (c.op == OP_CLR && ($urandom % 4) != 0) c.op = OP_ADD;
      c.s1  = 2'($urandom);
      c.s2  = 2'($urandom);
      c.d   = 2'($urandom);
      c.imm = W'($urandom);
      c.exp = model_result(c);
      run_cmd(c, $sformatf("rnd%0d op%0d", i, c.op));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // res_valid must never be high in two consecutive cycles.
  logic prev_rv = 1'b0;
  always @(negedge clk) begin
    if (res_valid && prev_rv) check("res_valid twice", 32'd1, 32'd0);
    prev_rv <= res_valid;
  end

endmodule
